// File: rtl/count_monitor.sv
// rtl/count_monitor.sv - legality monitor for a free-running CW-bit counter: wraps, stalls, skips, matches.
// Optional skip counter output enabled by defining COUNT_MONITOR_SKIP_COUNT_EN.
module count_monitor #(
    parameter int CW          = 4,
    parameter int WW          = 8,
    parameter int STALL_LIMIT = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [CW-1:0] count_in,
    input  logic          clear,
    input  logic [CW-1:0] match_value,
    output logic          wrap_pulse,
    output logic [WW-1:0] wrap_count,
    output logic          match_pulse,
    output logic          stalled,
    output logic          skip_err,
`ifdef COUNT_MONITOR_SKIP_COUNT_EN
    output logic [WW-1:0] skip_count,
`endif
    output logic [1:0]    mon_state
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_TRACK   = 2'd1,
        S_STALLED = 2'd2,
        S_ERROR   = 2'd3
    } state_t;

    localparam logic [CW-1:0] MAX   = {CW{1'b1}};
    localparam logic [3:0]    LIMIT = 4'(STALL_LIMIT);

    state_t        state_q, state_d;
    logic [CW-1:0] prev_q, prev_d;
    logic [3:0]    stall_q, stall_d;
    logic [WW-1:0] wrap_cnt_q, wrap_cnt_d;
    logic          wrap_pulse_q, wrap_pulse_d;
    logic          match_q, match_d;
    logic          stalled_q, stalled_d;
    logic          skip_err_q, skip_err_d;

    logic [CW-1:0] diff;
    logic [3:0]    stall_inc;
    logic          is_step, is_wrap, is_hold, is_restart, is_skip;

    assign diff       = count_in - prev_q;
    assign stall_inc  = stall_q + 4'd1;
    assign is_step    = (diff == CW'(1)) && (prev_q != MAX);
    assign is_wrap    = (prev_q == MAX) && (count_in == '0);
    assign is_hold    = (diff == '0);
    assign is_restart = (count_in == '0) && (prev_q != '0) && (prev_q != MAX);
    assign is_skip    = !(is_step || is_wrap || is_hold || is_restart);

    always_comb begin
        state_d      = state_q;
        prev_d       = count_in;
        stall_d      = stall_q;
        wrap_cnt_d   = wrap_cnt_q;
        wrap_pulse_d = 1'b0;
        match_d      = 1'b0;
        case (state_q)
            S_IDLE: begin
                state_d = S_TRACK;
                stall_d = '0;
            end
            S_TRACK, S_STALLED: begin
                match_d = (count_in == match_value) && !is_hold;
                if (is_hold) begin
                    // Counter saturates at LIMIT; only TRACK can reach it for the first time.
                    if (stall_q != LIMIT) stall_d = stall_inc;
                    if (stall_inc == LIMIT || state_q == S_STALLED) state_d = S_STALLED;
                end else if (is_skip) begin
                    state_d = S_ERROR;
                    stall_d = '0;
                end else begin
                    state_d = S_TRACK;
                    stall_d = '0;
                    if (is_wrap) begin
                        wrap_pulse_d = 1'b1;
                        if (!(&wrap_cnt_q)) wrap_cnt_d = wrap_cnt_q + WW'(1);
                    end
                end
            end
            default: ;
        endcase
        if (clear) begin
            state_d      = S_IDLE;
            stall_d      = '0;
            wrap_cnt_d   = '0;
            wrap_pulse_d = 1'b0;
            match_d      = 1'b0;
        end
        stalled_d  = (state_d == S_STALLED);
        skip_err_d = (state_d == S_ERROR);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            prev_q       <= '0;
            stall_q      <= '0;
            wrap_cnt_q   <= '0;
            wrap_pulse_q <= 1'b0;
            match_q      <= 1'b0;
            stalled_q    <= 1'b0;
            skip_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            prev_q       <= prev_d;
            stall_q      <= stall_d;
            wrap_cnt_q   <= wrap_cnt_d;
            wrap_pulse_q <= wrap_pulse_d;
            match_q      <= match_d;
            stalled_q    <= stalled_d;
            skip_err_q   <= skip_err_d;
        end
    end

`ifdef COUNT_MONITOR_SKIP_COUNT_EN
    logic [WW-1:0] skip_cnt_q, skip_cnt_d;

    always_comb begin
        skip_cnt_d = skip_cnt_q;
        if (clear)
            skip_cnt_d = '0;
        else if (is_skip && state_q != S_IDLE && !(&skip_cnt_q))
            skip_cnt_d = skip_cnt_q + WW'(1);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) skip_cnt_q <= '0;
        else        skip_cnt_q <= skip_cnt_d;
    end

    assign skip_count = skip_cnt_q;
`endif

    assign wrap_pulse  = wrap_pulse_q;
    assign wrap_count  = wrap_cnt_q;
    assign match_pulse = match_q;
    assign stalled     = stalled_q;
    assign skip_err    = skip_err_q;
    assign mon_state   = state_q;

endmodule

// File: tb/tb_count_monitor.sv
// tb/tb_count_monitor.sv - vector-table and scoreboard bench for count_monitor.
module tb_count_monitor;

    typedef struct {
        logic [3:0] cin;
        logic       clr;
        logic       wp;
        logic [7:0] wc;
        logic       mp;
        logic       st;
        logic       se;
        logic [1:0] ms;
    } vec_t;

    logic       clk;
    logic       reset;
    logic [3:0] count_in;
    logic       clear;
    logic [3:0] match_value;
    logic       wrap_pulse;
    logic [7:0] wrap_count;
    logic       match_pulse;
    logic       stalled;
    logic       skip_err;
    logic [1:0] mon_state;
`ifdef COUNT_MONITOR_SKIP_COUNT_EN
    logic [7:0] skip_count;
`endif

    int total = 0;
    int bad   = 0;
    vec_t tbl[$];
    vec_t exp_q[$];
    logic [3:0] m_prev;
    int         m_wc;

    count_monitor #(.CW(4), .WW(8), .STALL_LIMIT(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .count_in    (count_in),
        .clear       (clear),
        .match_value (match_value),
        .wrap_pulse  (wrap_pulse),
        .wrap_count  (wrap_count),
        .match_pulse (match_pulse),
        .stalled     (stalled),
        .skip_err    (skip_err),
`ifdef COUNT_MONITOR_SKIP_COUNT_EN
        .skip_count  (skip_count),
`endif
        .mon_state   (mon_state)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d", total);
        $fatal(1);
    end

    function automatic vec_t mk(input logic [3:0] c, input logic cl, input logic wp,
                                input logic [7:0] wc, input logic mp, input logic st,
                                input logic se, input logic [1:0] ms);
        vec_t v;
        v.cin = c; v.clr = cl; v.wp = wp; v.wc = wc;
        v.mp = mp; v.st = st; v.se = se; v.ms = ms;
        return v;
    endfunction

    task automatic check_outputs(input string tag);
        vec_t e;
        e = exp_q.pop_front();
        total++;
        if (wrap_pulse !== e.wp || wrap_count !== e.wc || match_pulse !== e.mp ||
            stalled !== e.st || skip_err !== e.se || mon_state !== e.ms) begin
            bad++;
            $display("FAIL %s cin=%0d: got wp=%0b wc=%0d mp=%0b st=%0b se=%0b ms=%0d, want wp=%0b wc=%0d mp=%0b st=%0b se=%0b ms=%0d",
                     tag, e.cin, wrap_pulse, wrap_count, match_pulse, stalled, skip_err, mon_state,
                     e.wp, e.wc, e.mp, e.st, e.se, e.ms);
        end
    endtask

    task automatic apply(input vec_t v, input string tag);
        @(negedge clk);
        count_in = v.cin;
        clear    = v.clr;
        exp_q.push_back(v);
        @(posedge clk);
        #1;
        check_outputs(tag);
    endtask

    // Reference for legal TRACK-only runs: wraps saturate at 255, matches only on change.
    task automatic sat_step(input logic [3:0] v);
        logic wp, mp;
        wp = (m_prev == 4'd15) && (v == 4'd0);
        if (wp && m_wc < 255) m_wc++;
        mp = (v == match_value) && (v != m_prev);
        apply(mk(v, 1'b0, wp, 8'(m_wc), mp, 1'b0, 1'b0, 2'd1), "sat");
        m_prev = v;
    endtask

    initial begin
        reset       = 1'b0;
        count_in    = 4'd0;
        clear       = 1'b0;
        match_value = 4'd5;

        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1));
        for (int i = 1; i <= 15; i++) tbl.push_back(mk(4'(i), 0, 0, 0, (i == 5), 0, 0, 1));
        tbl.push_back(mk(0, 0, 1, 1, 0, 0, 0, 1));
        for (int i = 1; i <= 4; i++) tbl.push_back(mk(4'(i), 0, 0, 1, 0, 0, 0, 1));
        tbl.push_back(mk(5, 0, 0, 1, 1, 0, 0, 1));
        tbl.push_back(mk(5, 0, 0, 1, 0, 0, 0, 1));
        tbl.push_back(mk(5, 0, 0, 1, 0, 0, 0, 1));
        tbl.push_back(mk(6, 0, 0, 1, 0, 0, 0, 1));
        tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0, 1));
        for (int k = 1; k <= 6; k++)
            tbl.push_back(mk(0, 0, 0, 1, 0, (k >= 4), 0, (k >= 4) ? 2'd2 : 2'd1));
        tbl.push_back(mk(1, 0, 0, 1, 0, 0, 0, 1));
        for (int i = 2; i <= 9; i++) tbl.push_back(mk(4'(i), 0, 0, 1, (i == 5), 0, 0, 1));
        tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0, 1));
        for (int i = 1; i <= 6; i++) tbl.push_back(mk(4'(i), 0, 0, 1, (i == 5), 0, 0, 1));
        tbl.push_back(mk(9, 0, 0, 1, 0, 0, 1, 3));
        tbl.push_back(mk(10, 0, 0, 1, 0, 0, 1, 3));
        tbl.push_back(mk(5, 0, 0, 1, 0, 0, 1, 3));
        for (int i = 6; i <= 15; i++) tbl.push_back(mk(4'(i), 0, 0, 1, 0, 0, 1, 3));
        tbl.push_back(mk(0, 0, 0, 1, 0, 0, 1, 3));
        tbl.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(2, 0, 0, 0, 0, 0, 0, 1));
        tbl.push_back(mk(3, 0, 0, 0, 0, 0, 0, 1));

        repeat (2) @(posedge clk);
        #1;
        exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0));
        check_outputs("reset");
        @(negedge clk);
        reset = 1'b1;

        for (int n = 0; n < tbl.size(); n++) apply(tbl[n], $sformatf("vec%0d", n));

        match_value = 4'd7;
        m_prev = 4'd3;
        m_wc   = 0;
        for (int i = 4; i <= 15; i++) sat_step(4'(i));
        for (int w = 0; w < 257; w++)
            for (int i = 0; i <= 15; i++) sat_step(4'(i));

        for (int k = 1; k <= 4; k++)
            apply(mk(15, 0, 0, 255, 0, (k >= 4), 0, (k >= 4) ? 2'd2 : 2'd1), "hold15");
        apply(mk(0, 0, 1, 255, 0, 0, 0, 1), "wrap_from_stalled");

        apply(mk(2, 1, 0, 0, 0, 0, 0, 0), "clear2");
        apply(mk(2, 0, 0, 0, 0, 0, 0, 1), "idle_to_track");
        apply(mk(7, 0, 0, 0, 1, 0, 1, 3), "skip_2_7");
        apply(mk(12, 0, 0, 0, 0, 0, 1, 3), "skip_7_12");
        apply(mk(3, 0, 0, 0, 0, 0, 1, 3), "skip_12_3");
`ifdef COUNT_MONITOR_SKIP_COUNT_EN
        total++;
        if (skip_count !== 8'd3) begin
            bad++;
            $display("FAIL skip_count: got %0d want 3", skip_count);
        end
`endif

        @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        exp_q.push_back(mk(3, 0, 0, 0, 0, 0, 0, 0));
        check_outputs("async_reset");
`ifdef COUNT_MONITOR_SKIP_COUNT_EN
        total++;
        if (skip_count !== 8'd0) begin
            bad++;
            $display("FAIL skip_count_reset: got %0d want 0", skip_count);
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/count_monitor.md
Name: count_monitor

Overview:
- Sits directly downstream of the free-running 4-bit `Counter` and samples its `count` output every clock.
- Checks that the count sequence is legal: +1 steps, wrap from max to 0, or an upstream reset to 0.
- Counts wrap-arounds, flags stalls and illegal skips, and pulses when the count reaches a programmable value.
- Status feeds the debug/status logic and the VCD dumps.

Parameters:
- CW, 4, width of the monitored count; matches `Counter`.
- WW, 8, width of the wrap counter and of the optional skip counter.
- STALL_LIMIT, 4, consecutive unchanged samples before `stalled` asserts; legal range 1..15.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset; all state cleared while low.
- count_in  in  CW  count value from the upstream counter.
- clear  in  1  synchronous clear of statistics and flags; active high.
- match_value  in  CW  compare value for match_pulse.
- wrap_pulse  out  1  one-cycle pulse on a legal max->0 transition.
- wrap_count  out  WW  number of wraps; saturating.
- match_pulse  out  1  one-cycle pulse when count newly equals match_value.
- stalled  out  1  count frozen for STALL_LIMIT or more samples.
- skip_err  out  1  sticky illegal-transition flag.
- mon_state  out  2  FSM state: 0 IDLE, 1 TRACK, 2 STALLED, 3 ERROR.

Behaviour:
- Clock and reset: one clock (`clk`). `reset` is asynchronous, active-low. All outputs are registered.
- Reset values (reset low): mon_state=IDLE, prev=0, stall_cnt=0, wrap_count=0; all pulses and flags 0.
- Latency: each rising edge compares count_in against prev (the previous sample). The result is visible on outputs after that same edge. Pulses are high for exactly one cycle.
- Classification, with MAX = 2^CW-1 and d = (count_in - prev) mod 2^CW:
  - STEP: d==1 and prev!=MAX.
  - WRAP: prev==MAX and count_in==0.
  - HOLD: d==0.
  - RESTART: count_in==0 and prev not in {0, MAX}.
  - SKIP: anything else.
- prev <= count_in on every edge in every state.
- IDLE:
  - Captures prev only; no checks and no pulses.
  - Next edge goes to TRACK.
- TRACK:
  - STEP: stall_cnt=0.
  - WRAP: wrap_pulse=1; wrap_count+1, saturating at all ones; stall_cnt=0.
  - HOLD: stall_cnt+1. When the new value equals STALL_LIMIT, go to STALLED and set stalled=1.
  - RESTART: stall_cnt=0; no error and no wrap.
  - SKIP: go to ERROR; skip_err=1.
- STALLED:
  - HOLD: remain; stall_cnt saturates.
  - STEP, WRAP or RESTART: go to TRACK; stalled=0; stall_cnt=0. A WRAP here also pulses and counts.
  - SKIP: go to ERROR; stalled=0.
- ERROR:
  - skip_err held at 1; wrap_count frozen; no wrap_pulse or match_pulse.
  - Exit only via clear or reset.
- match_pulse: asserted when count_in==match_value and d!=0, in TRACK or STALLED (evaluated before the transition). Never asserted in IDLE or ERROR. A held matching value pulses only once.
- clear:
  - Synchronous; overrides all other updates on that edge.
  - wrap_count=0, flags=0, stall_cnt=0, mon_state=IDLE; prev <= count_in.
- Reset going low mid-operation: immediate return to reset values, regardless of clock.
- Upstream counter held in its own reset (count stuck at 0) is treated as HOLD and produces stalled after STALL_LIMIT edges. This is not an error.

Optional Feature:
- Macro: COUNT_MONITOR_SKIP_COUNT_EN.
- Defined:
  - Adds output port skip_count [WW-1:0].
  - Increments on every SKIP classification in TRACK, STALLED and ERROR; saturates at all ones.
  - Reset and clear set it to 0.
- Undefined: port and logic are absent. All other behaviour is identical.

Test Plan:
- reset low for 2 cycles, then high; counter steps 0..15,0..3 -> wrap_count 0->1 after the 15->0 edge; wrap_pulse high one cycle; skip_err=0; mon_state=1.
- match_value=5, counter steps through 5 once, then holds at 5 for 2 cycles -> exactly one match_pulse, on the 4->5 edge; none during the hold.
- counter held at 0 (upstream reset) for 6 cycles, STALL_LIMIT=4 -> stalled=1 after the 4th unchanged sample, mon_state=2. Release to 1 -> stalled=0, mon_state=1, no skip_err.
- counter at 9 forced to 0 -> RESTART: no skip_err, wrap_count unchanged. Counter 6 forced to 9 -> skip_err=1, mon_state=3, and it remains so through later legal steps until clear pulses -> all 0, mon_state=0.
- wrap_count driven to 255 (WW=8) by 256 wraps, then one more wrap -> wrap_count stays 255; wrap_pulse still pulses.
- With COUNT_MONITOR_SKIP_COUNT_EN: three skips (2->7, 7->12, 12->3) -> skip_count=3. Reset asserted low mid-sequence -> skip_count=0 and all outputs at reset values immediately, before the next clk edge.
